// File: rtl/mfc_framer.sv
// Pre-emphasis + overlapping framer: filters PCM samples into a circular RAM
// and streams FRAME_LEN-word frames every FRAME_SHIFT samples over ready/valid.
module mfc_framer #(
    parameter int          FRAME_LEN   = 256,
    parameter int          FRAME_SHIFT = 128,
    parameter int unsigned PRE_COEF    = 31785
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dv,
    input  logic [15:0] dat_i,
    input  logic        frm_ready,
    output logic        frm_valid,
    output logic [15:0] frm_dat,
    output logic        frm_first,
    output logic        frm_last,
    output logic [15:0] frm_cnt,
    output logic        overrun
);
    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(FRAME_LEN);
    localparam logic signed [31:0] COEF = 32'(PRE_COEF);

    typedef enum logic {IDLE, READ} state_t;

    logic [15:0]        mem [DEPTH];
    state_t             st_q;
    logic signed [15:0] x_prev_q;
    logic [AW-1:0]      wp_q, rd_ptr_q;
    logic [IW-1:0]      cnt_q, idx_q;
    logic               primed_q, dropped_q;
    logic               vld_q, first_q, last_q, ovr_q;
    logic [15:0]        dat_q, fcnt_q;

    logic signed [31:0] prod, shifted, diff;
    logic [15:0]        y;
    logic               due, hs, start;
    logic [AW-1:0]      base;

    // y = x - floor(coef * x_prev / 2^15), clamped to 16-bit signed range
    always_comb begin
        prod    = COEF * 32'(x_prev_q);
        shifted = prod >>> 15;
        diff    = 32'($signed(dat_i)) - shifted;
        if (diff > 32'sd32767)       y = 16'h7fff;
        else if (diff < -32'sd32768) y = 16'h8000;
        else                         y = diff[15:0];
    end

    assign due   = dv && (primed_q ? (cnt_q == IW'(FRAME_SHIFT - 1))
                                   : (cnt_q == IW'(FRAME_LEN - 1)));
    assign hs    = vld_q && frm_ready;
    // Oldest of the last FRAME_LEN samples, counting the one written this cycle
    assign base  = wp_q - AW'(FRAME_LEN - 1);
    assign start = due && (st_q == IDLE || (hs && last_q));

    always_ff @(posedge clk) begin
        if (dv) mem[wp_q] <= y;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= IDLE;
            x_prev_q  <= '0;
            wp_q      <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            primed_q  <= 1'b0;
            dropped_q <= 1'b0;
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            ovr_q     <= 1'b0;
            dat_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            if (dv) begin
                x_prev_q <= $signed(dat_i);
                wp_q     <= wp_q + 1'b1;
                cnt_q    <= due ? '0 : cnt_q + 1'b1;
                if (due) primed_q <= 1'b1;
            end
            if (hs && last_q) fcnt_q <= fcnt_q + 16'd1;

            if (start) begin
                // word 0 was written long ago, so it can be loaded on the due edge
                st_q      <= READ;
                vld_q     <= 1'b1;
                first_q   <= 1'b1;
                last_q    <= 1'b0;
                dat_q     <= mem[base];
                rd_ptr_q  <= base + 1'b1;
                idx_q     <= '0;
                dropped_q <= 1'b0;
            end else if (st_q == READ) begin
                if (hs && last_q) begin
                    st_q    <= IDLE;
                    vld_q   <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                end else if (due && dropped_q) begin
                    st_q      <= IDLE;
                    vld_q     <= 1'b0;
                    first_q   <= 1'b0;
                    last_q    <= 1'b0;
                    dropped_q <= 1'b0;
                    ovr_q     <= 1'b1;
                end else begin
                    if (due) begin
                        dropped_q <= 1'b1;
                        ovr_q     <= 1'b1;
                    end
                    if (hs) begin
                        dat_q    <= mem[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        idx_q    <= idx_q + 1'b1;
                        first_q  <= 1'b0;
                        last_q   <= (idx_q == IW'(FRAME_LEN - 2));
                    end
                end
            end
        end
    end

    assign frm_valid = vld_q;
    assign frm_dat   = dat_q;
    assign frm_first = first_q;
    assign frm_last  = last_q;
    assign frm_cnt   = fcnt_q;
    assign overrun   = ovr_q;
endmodule
